// File: rtl/pe_arith_pkg.sv
// Shared types and helpers for the PE arithmetic blocks (serial adder, subtractor).
package pe_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

  // Counter width for n chunks; never narrower than one bit so the counter always exists.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder_n.sv
// Combinational ripple-carry adder; bit 0 collapses to a half adder when carry-in is unused.
module adder_n #(
  parameter int nb_bit       = 1,
  parameter bit use_carry_in = 1'b1
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  input  logic              carry_i,
  output logic [nb_bit-1:0] sum_o,
  output logic              carry_o
);

  logic [nb_bit:0] c;

  assign c[0] = use_carry_in ? carry_i : 1'b0;

  for (genvar i = 0; i < nb_bit; i++) begin : g_bit
    if (i == 0 && !use_carry_in) begin : g_half
      assign sum_o[i] = a_i[i] ^ b_i[i];
      assign c[i+1]   = a_i[i] & b_i[i];
    end else begin : g_full
      assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign carry_o = c[nb_bit];

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder: sums chunk_bit bits per clock, LSB chunk first, behind valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds valid and data stable until that edge, and ready never depends on valid.
module serial_adder_n
  import pe_arith_pkg::*;
#(
  parameter int nb_bit    = 8,
  parameter int chunk_bit = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  input  logic              carry_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [nb_bit-1:0] sum_o,
  output logic              carry_o,
  output serial_state_t     state_o
);

  localparam int nb_chunk = nb_bit / chunk_bit;
  localparam int cnt_w    = clog2_min1(nb_chunk);

  if (nb_bit < 1 || chunk_bit < 1 || (nb_bit % chunk_bit) != 0) begin : g_bad_params
    $error("serial_adder_n: nb_bit must be >= 1 and a multiple of chunk_bit");
  end

  serial_state_t         state_q, state_d;
  logic [nb_bit-1:0]     a_q, b_q, sum_q;
  logic                  carry_q, carry_out_q;
  logic [cnt_w-1:0]      cnt_q;
  logic [chunk_bit-1:0]  chunk_sum;
  logic                  chunk_carry;
  logic                  last_chunk;

  adder_n #(
    .nb_bit       (chunk_bit),
    .use_carry_in (1'b1)
  ) u_chunk_add (
    .a_i     (a_q[chunk_bit-1:0]),
    .b_i     (b_q[chunk_bit-1:0]),
    .carry_i (carry_q),
    .sum_o   (chunk_sum),
    .carry_o (chunk_carry)
  );

  assign last_chunk = (cnt_q == cnt_w'(nb_chunk - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i)    state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (ready_i)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // carry_q feeds the chunk adder; carry_out_q is the visible result and only moves during RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= carry_i;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q         <= a_q >> chunk_bit;
          b_q         <= b_q >> chunk_bit;
          sum_q       <= nb_bit'({chunk_sum, sum_q} >> chunk_bit);
          carry_q     <= chunk_carry;
          carry_out_q <= chunk_carry;
          cnt_q       <= cnt_q + cnt_w'(1);
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign sum_o   = sum_q;
  assign carry_o = carry_out_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and randomized checks of serial_adder_n at chunk widths 1, 4, 2 and 8 (nb_bit = 8).
module tb_serial_adder_n;
  import pe_arith_pkg::*;

  localparam int nd = 4;
  localparam int ck[nd] = '{1, 4, 2, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic          rst[nd];
  logic          valid_i[nd], ready_i[nd], carry_i[nd];
  logic [7:0]    a_i[nd], b_i[nd];
  logic          ro[nd], vo[nd], co[nd];
  logic [7:0]    so[nd];
  serial_state_t st[nd];

  for (genvar g = 0; g < nd; g++) begin : g_dut
    serial_adder_n #(.nb_bit(8), .chunk_bit(ck[g])) u_dut (
      .clk_i   (clk),
      .rst_i   (rst[g]),
      .valid_i (valid_i[g]),
      .ready_o (ro[g]),
      .a_i     (a_i[g]),
      .b_i     (b_i[g]),
      .carry_i (carry_i[g]),
      .valid_o (vo[g]),
      .ready_i (ready_i[g]),
      .sum_o   (so[g]),
      .carry_o (co[g]),
      .state_o (st[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nchunk(input int d);
    return 8 / ck[d];
  endfunction

  task automatic test_reset();
    for (int d = 0; d < nd; d++) begin
      rst[d] = 1'b1; valid_i[d] = 1'b0; ready_i[d] = 1'b0;
      carry_i[d] = 1'b0; a_i[d] = 8'h00; b_i[d] = 8'h00;
    end
    step(); step();
    for (int d = 0; d < nd; d++) rst[d] = 1'b0;
    for (int d = 0; d < nd; d++) begin
      checks++; if (ro[d] !== 1'b1) begin errors++; $display("FAIL reset_ready d%0d: got %b want 1", d, ro[d]); end
      checks++; if (vo[d] !== 1'b0) begin errors++; $display("FAIL reset_valid d%0d: got %b want 0", d, vo[d]); end
      checks++; if (so[d] !== 8'h00) begin errors++; $display("FAIL reset_sum d%0d: got %h want 00", d, so[d]); end
      checks++; if (co[d] !== 1'b0) begin errors++; $display("FAIL reset_carry d%0d: got %b want 0", d, co[d]); end
      checks++; if (st[d] !== IDLE) begin errors++; $display("FAIL reset_state d%0d: got %0d want IDLE", d, st[d]); end
    end
  endtask

  // One full operation with latency check, then the result handshake.
  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input string name);
    int lat;
    a_i[d] = a; b_i[d] = b; carry_i[d] = c; valid_i[d] = 1'b1;
    step();
    valid_i[d] = 1'b0;
    lat = 1;
    while (!vo[d] && lat < 100) begin
      step();
      lat++;
    end
    checks++; if (lat !== nchunk(d) + 1) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, nchunk(d) + 1); end
    checks++; if (so[d] !== es) begin errors++; $display("FAIL %s_sum: got %h want %h", name, so[d], es); end
    checks++; if (co[d] !== ec) begin errors++; $display("FAIL %s_carry: got %b want %b", name, co[d], ec); end
    checks++; if (ro[d] !== 1'b0) begin errors++; $display("FAIL %s_busy_ready: got %b want 0", name, ro[d]); end
    ready_i[d] = 1'b1;
    step();
    ready_i[d] = 1'b0;
    checks++; if (ro[d] !== 1'b1) begin errors++; $display("FAIL %s_idle_ready: got %b want 1", name, ro[d]); end
    checks++; if (so[d] !== es) begin errors++; $display("FAIL %s_sum_held: got %h want %h", name, so[d], es); end
    checks++; if (st[d] !== IDLE) begin errors++; $display("FAIL %s_idle_state: got %0d want IDLE", name, st[d]); end
  endtask

  task automatic test_directed();
    run_op(0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "c1_5a_33");
    run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "c1_ff_01");
    run_op(0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "c1_ff_00_cin");
    run_op(1, 8'h9C, 8'h7B, 1'b1, 8'h18, 1'b1, "c4_9c_7b_cin");
    run_op(2, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, "c2_aa_55_cin");
    run_op(3, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "c8_80_80");
    run_op(3, 8'h21, 8'h42, 1'b1, 8'h64, 1'b0, "c8_21_42_cin");
  endtask

  task automatic test_backpressure();
    int w;
    a_i[0] = 8'h12; b_i[0] = 8'h34; carry_i[0] = 1'b0; valid_i[0] = 1'b1;
    step();
    valid_i[0] = 1'b0;
    w = 0;
    while (!vo[0] && w < 100) begin step(); w++; end
    for (int i = 0; i < 5; i++) begin
      valid_i[0] = (i % 2 == 0); a_i[0] = 8'hFF; b_i[0] = 8'hFF; carry_i[0] = 1'b1;
      step();
      checks++; if (vo[0] !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", i, vo[0]); end
      checks++; if (so[0] !== 8'h46) begin errors++; $display("FAIL bp_sum c%0d: got %h want 46", i, so[0]); end
      checks++; if (co[0] !== 1'b0) begin errors++; $display("FAIL bp_carry c%0d: got %b want 0", i, co[0]); end
      checks++; if (ro[0] !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b want 0", i, ro[0]); end
    end
    valid_i[0] = 1'b0; ready_i[0] = 1'b1;
    step();
    ready_i[0] = 1'b0;
    checks++; if (ro[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", ro[0]); end
    checks++; if (vo[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", vo[0]); end
  endtask

  task automatic test_reset_mid_run();
    a_i[0] = 8'hFF; b_i[0] = 8'h01; carry_i[0] = 1'b1; valid_i[0] = 1'b1;
    step();
    valid_i[0] = 1'b0;
    step(); step(); step();
    checks++; if (st[0] !== RUN) begin errors++; $display("FAIL midrun_state: got %0d want RUN", st[0]); end
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    checks++; if (st[0] !== IDLE) begin errors++; $display("FAIL midrun_rst_state: got %0d want IDLE", st[0]); end
    checks++; if (ro[0] !== 1'b1) begin errors++; $display("FAIL midrun_rst_ready: got %b want 1", ro[0]); end
    checks++; if (vo[0] !== 1'b0) begin errors++; $display("FAIL midrun_rst_valid: got %b want 0", vo[0]); end
    checks++; if (so[0] !== 8'h00) begin errors++; $display("FAIL midrun_rst_sum: got %h want 00", so[0]); end
    checks++; if (co[0] !== 1'b0) begin errors++; $display("FAIL midrun_rst_carry: got %b want 0", co[0]); end
    run_op(0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "after_rst");
  endtask

  task automatic test_random(input int d, input int n);
    logic [8:0] exp_q[$];
    int got;
    got = 0;
    fork
      begin : drv
        for (int i = 0; i < n; i++) begin
          logic [7:0] ra, rb;
          logic rc;
          int wait_cyc;
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          rc = 1'($urandom_range(0, 1));
          a_i[d] = ra; b_i[d] = rb; carry_i[d] = rc; valid_i[d] = 1'b1;
          wait_cyc = 0;
          while (!ro[d] && wait_cyc < 1000) begin step(); wait_cyc++; end
          if (!ro[d]) begin
            checks++; errors++;
            $display("FAIL rand_accept_timeout d%0d: got ready 0 want 1", d);
            valid_i[d] = 1'b0;
            break;
          end
          exp_q.push_back(9'(ra) + 9'(rb) + 9'(rc));
          step();
          valid_i[d] = 1'b0;
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin : mon
        int cyc;
        logic [8:0] e;
        cyc = 0;
        while (got < n && cyc < 15000) begin
          ready_i[d] = ($urandom_range(0, 3) != 0);
          if (vo[d] && ready_i[d]) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rand_extra_result d%0d: got %h want none", d, {co[d], so[d]});
            end else begin
              e = exp_q.pop_front();
              if ({co[d], so[d]} !== e) begin
                errors++;
                $display("FAIL rand_result d%0d #%0d: got %h want %h", d, got, {co[d], so[d]}, e);
              end
            end
            got++;
          end
          step();
          cyc++;
        end
        ready_i[d] = 1'b0;
      end
    join
    checks++;
    if (got != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count d%0d: got %0d results (%0d pending) want %0d", d, got, exp_q.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random(0, 500);
    test_random(2, 500);
    test_random(3, 500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
